// File: rtl/alu.sv
// Registered 32-bit execute-stage ALU: AND/OR/ADD/SUB/SLT/NOR selected by ALUControl.
// Latency: 1 cycle, with result and zero flag captured on every rising clk edge.
// Backpressure: none; it accepts a new operation every cycle.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [2:0]  ALUControl,
    output logic [31:0] ALUResult,
    output logic        Zero
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_NOR = 3'b100,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_t;

    logic [31:0] sum_res;
    logic [31:0] sub_res;
    logic        slt_bit;
    logic [31:0] result_d;
    logic        zero_d;
    logic [31:0] result_q;
    logic        zero_q;

    assign sum_res = SrcA + SrcB;
    assign sub_res = SrcA + ~SrcB + 32'd1;
    // On differing signs the difference can overflow, so the negative operand is the smaller one.
    assign slt_bit = (SrcA[31] != SrcB[31]) ? SrcA[31] : sub_res[31];

    always_comb begin
        result_d = 32'd0;
        case (ALUControl)
            OP_AND:  result_d = SrcA & SrcB;
            OP_OR:   result_d = SrcA | SrcB;
            OP_ADD:  result_d = sum_res;
            OP_SUB:  result_d = sub_res;
            OP_SLT:  result_d = {31'd0, slt_bit};
            OP_NOR:  result_d = ~(SrcA | SrcB);
            default: result_d = 32'd0;
        endcase
        zero_d = (result_d == 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= 32'd0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset, every opcode, boundary cases and a back-to-back stream.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;

    int vectors;
    int miscompares;

    alu dut (
        .clk        (clk),
        .reset      (reset),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] exp_r, input logic exp_z);
        chk(tag, ALUResult, exp_r);
        chk({tag, ".zero"}, {31'd0, Zero}, {31'd0, exp_z});
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic z);
        @(negedge clk);
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        @(posedge clk);
        #1;
        chk_out(tag, r, z);
    endtask

    logic [2:0]  s_op [6];
    logic [31:0] s_a  [6];
    logic [31:0] s_b  [6];
    logic [31:0] s_r  [6];
    logic        s_z  [6];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        SrcA        = 32'd0;
        SrcB        = 32'd0;
        ALUControl  = 3'b000;

        s_op[0] = 3'b010; s_a[0] = 32'h0000_0001; s_b[0] = 32'h0000_0002; s_r[0] = 32'h0000_0003; s_z[0] = 1'b0;
        s_op[1] = 3'b110; s_a[1] = 32'h0000_0005; s_b[1] = 32'h0000_0007; s_r[1] = 32'hFFFF_FFFE; s_z[1] = 1'b0;
        s_op[2] = 3'b000; s_a[2] = 32'hF0F0_0000; s_b[2] = 32'hFF00_FF00; s_r[2] = 32'hF000_0000; s_z[2] = 1'b0;
        s_op[3] = 3'b111; s_a[3] = 32'hFFFF_FFFF; s_b[3] = 32'h0000_0000; s_r[3] = 32'h0000_0001; s_z[3] = 1'b0;
        s_op[4] = 3'b100; s_a[4] = 32'h0000_0000; s_b[4] = 32'h0000_0000; s_r[4] = 32'hFFFF_FFFF; s_z[4] = 1'b0;
        s_op[5] = 3'b001; s_a[5] = 32'h0000_0000; s_b[5] = 32'h0000_0000; s_r[5] = 32'h0000_0000; s_z[5] = 1'b1;

        #1;
        chk_out("reset_initial", 32'h0000_0000, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        run("and",      3'b000, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1);
        run("or",       3'b001, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0);
        run("nor",      3'b100, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1);
        run("add",      3'b010, 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 1'b0);
        run("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        run("sub_eq",   3'b110, 32'h0000_000F, 32'h0000_000F, 32'h0000_0000, 1'b1);
        run("sub_neg",  3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        run("slt_lt",   3'b111, 32'h0000_000A, 32'h0000_000F, 32'h0000_0001, 1'b0);
        run("slt_gt",   3'b111, 32'h0000_000F, 32'h0000_000A, 32'h0000_0000, 1'b1);
        run("slt_sgn",  3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0);
        run("slt_ovf0", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1);
        run("slt_ovf1", 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run("slt_eq",   3'b111, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1);
        run("undef011", 3'b011, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1);
        run("undef101", 3'b101, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1);

        // Asynchronous reset mid-cycle while the outputs hold a non-zero value.
        run("pre_reset", 3'b001, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_out("reset_async", 32'h0000_0000, 1'b1);
        @(posedge clk);
        #1;
        chk_out("reset_hold", 32'h0000_0000, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_out("reset_release", 32'h0000_0000, 1'b1);
        @(posedge clk);
        #1;
        chk_out("post_reset", 32'hFFFF_FFFF, 1'b0);

        // Back-to-back stream with mid-cycle input toggling.
        @(negedge clk);
        ALUControl = s_op[0];
        SrcA       = s_a[0];
        SrcB       = s_b[0];
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("stream%0d", i), s_r[i], s_z[i]);
            #1;
            ALUControl = 3'b001;
            SrcA       = ~s_a[i];
            SrcB       = 32'h1357_9BDF;
            #2;
            chk_out($sformatf("stream%0d_hold", i), s_r[i], s_z[i]);
            @(negedge clk);
            if (i < 5) begin
                ALUControl = s_op[i+1];
                SrcA       = s_a[i+1];
                SrcB       = s_b[i+1];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
